// File: rtl/data_mem_access_unit_if.sv
// Bus bundle between the execute-stage requester, data_mem_access_unit and data_memory.
// The master view is the requester plus memory side; the slave view is the access unit.
interface data_mem_access_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] wdata;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_read_data,
        input  req_ready, wdata_ready, rdata, rdata_valid, busy, done,
               mem_address, mem_write_data, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wdata, wdata_valid, mem_read_data,
        output req_ready, wdata_ready, rdata, rdata_valid, busy, done,
               mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Data-memory initiator: serialises 1..16 byte sequential load/store bursts onto
// the data_memory port and streams load bytes back two cycles after each read.
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// RD      | one mem_read per cycle, address increments
// RD_WAIT | last read byte still in flight from memory
// WR      | one mem_write per cycle with wdata_valid, stalls otherwise
// DONE    | one-cycle completion pulse
module data_mem_access_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input logic clk,
    input logic reset,
    data_mem_access_unit_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic              rd_pend;
    logic [DATA_W-1:0] rdata_reg;
    logic              rdata_valid_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nx = bus.req_write ? WR : RD;
            RD:      if (cnt_reg == '0) state_nx = RD_WAIT;
            RD_WAIT: state_nx = DONE;
            WR:      if (bus.wdata_valid && cnt_reg == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = 1'b0;
        bus.busy           = 1'b1;
        bus.done           = 1'b0;
        bus.mem_read       = 1'b0;
        bus.mem_write      = 1'b0;
        bus.wdata_ready    = 1'b0;
        bus.mem_address    = '0;
        bus.mem_write_data = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            RD: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = addr_reg;
            end
            WR: begin
                bus.wdata_ready    = 1'b1;
                bus.mem_address    = addr_reg;
                bus.mem_write_data = bus.wdata;
                bus.mem_write      = bus.wdata_valid;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    // Memory registers read data one cycle after mem_read; rd_pend tracks that slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg        <= '0;
            cnt_reg         <= '0;
            rd_pend         <= 1'b0;
            rdata_reg       <= '0;
            rdata_valid_reg <= 1'b0;
        end else begin
            rd_pend         <= (state == RD);
            rdata_valid_reg <= rd_pend;
            if (rd_pend) rdata_reg <= bus.mem_read_data;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_reg <= bus.req_addr;
                        cnt_reg  <= bus.req_len;
                    end
                end
                RD: begin
                    addr_reg <= addr_reg + 1'b1;
                    cnt_reg  <= cnt_reg - 1'b1;
                end
                WR: begin
                    if (bus.wdata_valid) begin
                        addr_reg <= addr_reg + 1'b1;
                        cnt_reg  <= cnt_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rdata       = rdata_reg;
    assign bus.rdata_valid = rdata_valid_reg;
endmodule
